// File: rtl/rf_wb_arb_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Holds the FSM state type, the requester IDs and the register-file geometry
// (data and address widths), which are also used by the register file itself.
package rf_wb_arb_pkg;

  // Register-file geometry: 2^RF_AW registers of RF_DW bits each.
  localparam int unsigned RF_DW = 32;
  localparam int unsigned RF_AW = 5;

  // Requester IDs. These also index the arbiter's valid and grant vectors.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic {
    StRun,
    StClear
  } state_e;

endpackage

// File: rtl/rf_wb_arb_rr.sv
// rr_arb2: 2-way round-robin arbiter with a one-hot grant output.
// Ports:
//   valid  in  2  request vector, indexed by requester ID
//   prio   in  1  ID of the requester that wins a tie
//   en     in  1  grant enable; both grants are 0 when low
//   gnt    out 2  one-hot (or zero) grant vector, indexed by requester ID
module rr_arb2
  import rf_wb_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  input  logic       en,
  output logic [1:0] gnt
);

  // A lone requester always wins; on a tie the prio holder wins.
  assign gnt[REQ_A] = en & valid[REQ_A] & (~valid[REQ_B] | (prio == REQ_A));
  assign gnt[REQ_B] = en & valid[REQ_B] & (~valid[REQ_A] | (prio == REQ_B));

endmodule

// File: rtl/rf_wb_arb.sv
// rf_wb_arb: write-back arbiter and clear sequencer for the register file's
// single write port. Two requesters (A: ALU, B: load) are arbitrated
// round-robin. A clear sweep zeroes registers 1..2^AW-1 on request and,
// optionally, after reset, because the register file itself has no reset.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   clr_req / clr_busy          clear-sweep request (RUN only) / sweep active
//   a_valid/a_ready/a_addr/a_data  requester A handshake and payload
//   b_valid/b_ready/b_addr/b_data  requester B handshake and payload
//   rf_we/rf_rw/rf_wd           registered register-file write port
//   last_b                      most recent grant went to B
module rf_wb_arb
  import rf_wb_arb_pkg::*;
#(
  parameter int unsigned DW         = RF_DW,
  parameter int unsigned AW         = RF_AW,
  parameter bit          CLR_ON_RST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_rw,
  output logic [DW-1:0] rf_wd,
  output logic          last_b
);

  localparam logic [AW-1:0] CntFirst = AW'(1);
  localparam logic [AW-1:0] CntLast  = {AW{1'b1}};

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          pend_clr_q, pend_clr_d;
  logic          prio_q, prio_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_rw_q, rf_rw_d;
  logic [DW-1:0] rf_wd_q, rf_wd_d;
  logic          last_b_q, last_b_d;

  logic          clr_start;
  logic          arb_en;
  logic [1:0]    gnt;

  // A clear start makes the current RUN cycle dead: nobody is granted.
  assign clr_start = clr_req | pend_clr_q;
  assign arb_en    = (state_q == StRun) & ~clr_start;

  rr_arb2 u_arb (
    .valid ({b_valid, a_valid}),
    .prio  (prio_q),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign a_ready  = gnt[REQ_A];
  assign b_ready  = gnt[REQ_B];
  assign clr_busy = (state_q == StClear);
  assign rf_we    = rf_we_q;
  assign rf_rw    = rf_rw_q;
  assign rf_wd    = rf_wd_q;
  assign last_b   = last_b_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_clr_d = pend_clr_q;
    prio_d     = prio_q;
    rf_we_d    = 1'b0;
    rf_rw_d    = rf_rw_q;
    rf_wd_d    = rf_wd_q;
    last_b_d   = last_b_q;
    unique case (state_q)
      StRun: begin
        if (clr_start) begin
          state_d    = StClear;
          cnt_d      = CntFirst;
          pend_clr_d = 1'b0;
        end else if (gnt[REQ_A]) begin
          // Writes to register 0 handshake normally but are dropped.
          rf_we_d  = (a_addr != '0);
          rf_rw_d  = a_addr;
          rf_wd_d  = a_data;
          prio_d   = REQ_B;
          last_b_d = 1'b0;
        end else if (gnt[REQ_B]) begin
          rf_we_d  = (b_addr != '0);
          rf_rw_d  = b_addr;
          rf_wd_d  = b_data;
          prio_d   = REQ_A;
          last_b_d = 1'b1;
        end
      end
      StClear: begin
        rf_we_d = 1'b1;
        rf_rw_d = cnt_q;
        rf_wd_d = '0;
        if (cnt_q == CntLast) begin
          // Terminate instead of wrapping; leave cnt ready for the next sweep.
          state_d = StRun;
          cnt_d   = CntFirst;
        end else begin
          cnt_d = cnt_q + CntFirst;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      cnt_q      <= CntFirst;
      pend_clr_q <= CLR_ON_RST;
      prio_q     <= REQ_A;
      rf_we_q    <= 1'b0;
      rf_rw_q    <= '0;
      rf_wd_q    <= '0;
      last_b_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_clr_q <= pend_clr_d;
      prio_q     <= prio_d;
      rf_we_q    <= rf_we_d;
      rf_rw_q    <= rf_rw_d;
      rf_wd_q    <= rf_wd_d;
      last_b_q   <= last_b_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arb.sv
// Directed testbench for rf_wb_arb with hand-computed expected values.
module tb_rf_wb_arb;
  import rf_wb_arb_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_req;
  logic          clr_busy;
  logic          a_valid, a_ready;
  logic [4:0]    a_addr;
  logic [31:0]   a_data;
  logic          b_valid, b_ready;
  logic [4:0]    b_addr;
  logic [31:0]   b_data;
  logic          rf_we;
  logic [4:0]    rf_rw;
  logic [31:0]   rf_wd;
  logic          last_b;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_arb #(
    .DW         (32),
    .AW         (5),
    .CLR_ON_RST (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .rf_we    (rf_we),
    .rf_rw    (rf_rw),
    .rf_wd    (rf_wd),
    .last_b   (last_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr_req = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    repeat (3) tick();

    // Reset values
    check("rst_we", rf_we, 0);
    check("rst_rw", rf_rw, 0);
    check("rst_wd", rf_wd, 0);
    check("rst_busy", clr_busy, 0);
    check("rst_lastb", last_b, 0);

    // Auto clear after reset, with both requesters pushing throughout
    rst = 1'b0;
    a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h1111_1111;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h2222_2222;
    #1;
    check("dead_busy", clr_busy, 0);
    check("dead_aready", a_ready, 0);
    check("dead_bready", b_ready, 0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 32) begin
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
      end
      check("sweep_busy", clr_busy, (k <= 31) ? 1 : 0);
      check("sweep_we", rf_we, (k >= 2) ? 1 : 0);
      if (k >= 2) begin
        check("sweep_rw", rf_rw, k - 1);
        check("sweep_wd", rf_wd, 0);
      end
      check("sweep_aready", a_ready, 0);
      check("sweep_bready", b_ready, 0);
    end
    tick();
    check("sweep_end_we", rf_we, 0);

    // A alone
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    check("a_alone_ready", a_ready, 1);
    check("a_alone_bready", b_ready, 0);
    tick();
    a_valid = 1'b0;
    check("a_alone_we", rf_we, 1);
    check("a_alone_rw", rf_rw, 5);
    check("a_alone_wd", rf_wd, 32'hDEAD_BEEF);
    check("a_alone_lastb", last_b, 0);

    // B writes register 0: handshake completes, write dropped, prio back to A
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0000_1234;
    #1;
    check("b_r0_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    check("b_r0_we", rf_we, 0);
    check("b_r0_lastb", last_b, 1);

    // Contention for 4 cycles starting with prio = A
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h0000_00A0;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_00B0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_aready", a_ready, (i % 2 == 0) ? 1 : 0);
      check("rr_bready", b_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      check("rr_lastb", last_b, (i % 2 == 1) ? 1 : 0);
      check("rr_we", rf_we, 1);
      check("rr_rw", rf_rw, (i % 2 == 1) ? 7 : 3);
      check("rr_wd", rf_wd, (i % 2 == 1) ? 32'hB0 : 32'hA0);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    check("idle_we", rf_we, 0);
    check("idle_rw_hold", rf_rw, 7);
    check("idle_wd_hold", rf_wd, 32'hB0);

    // clr_req while A valid; second pulse mid-sweep is ignored
    clr_req = 1'b1;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0055;
    #1;
    check("clr_dead_aready", a_ready, 0);
    tick();
    for (int k = 0; k < 31; k++) begin
      clr_req = (k == 10);
      #1;
      check("clr_busy", clr_busy, 1);
      check("clr_aready", a_ready, 0);
      tick();
    end
    clr_req = 1'b0;
    #1;
    check("clr_done_busy", clr_busy, 0);
    check("clr_done_aready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("clr_a_we", rf_we, 1);
    check("clr_a_rw", rf_rw, 9);
    check("clr_a_wd", rf_wd, 32'h55);
    tick();
    check("clr_no_requeue", clr_busy, 0);
    check("clr_no_requeue_we", rf_we, 0);

    // Reset in the middle of a sweep at register 17
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (17) tick();
    check("mid_rw", rf_rw, 17);
    check("mid_we", rf_we, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_we", rf_we, 0);
    check("mid_rst_busy", clr_busy, 0);
    check("mid_rst_rw", rf_rw, 0);
    rst = 1'b0;
    tick();
    check("restart_busy", clr_busy, 1);
    check("restart_we0", rf_we, 0);
    tick();
    check("restart_we", rf_we, 1);
    check("restart_rw", rf_rw, 1);
    repeat (32) tick();
    check("restart_done_busy", clr_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
